addsub_arbiter: RTL and testbench
=================================

// Module: addsub_arbiter
// PURPOSE
//  Shares one addSub_16bit datapath between two requesters, e.g. the ALU-op
//  path and the address/PC-offset path of the basic CPU.
//  Round-robin arbitration with a valid/grant request handshake.
//  Operands and results are registered; the result is returned with requester
//  ID, carry and signed-overflow flag.
//  Result is held under valid/ready backpressure until consumed.
// PARAMETERS
//  WIDTH  16  operand/result width; only 16 is legal (fixed by addSub_16bit)
//  FAIR   1   1 = round-robin between requesters; 0 = fixed priority, req0 wins
// PORTS
//  iClk      in   1      clock, rising edge
//  iRst      in   1      reset, synchronous, active-high
//  iReq0     in   1      requester 0 has an operation pending
//  iA0, iB0  in   WIDTH  requester 0 operands
//  iSel0     in   1      requester 0 op: 0 = A+B, 1 = A-B
//  oGnt0     out  1      requester 0 operands accepted this cycle
//  iReq1     in   1      requester 1 has an operation pending
//  iA1, iB1  in   WIDTH  requester 1 operands
//  iSel1     in   1      requester 1 op: 0 = A+B, 1 = A-B
//  oGnt1     out  1      requester 1 operands accepted this cycle
//  oRValid   out  1      result valid
//  iRReady   in   1      consumer accepts result
//  oS        out  WIDTH  sum/difference
//  oC        out  1      carry out of addSub_16bit
//  oOvf      out  1      signed overflow
//  oId       out  1      requester that issued this result
// BEHAVIOUR
//  Reset (iRst=1 at edge): state=IDLE; oRValid=0, oS=0, oC=0, oOvf=0, oId=0;
//   priority pointer -> req0; operand regs cleared. Reset overrides any state.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE:
//   - oGntX is combinational: high only in IDLE, at most one grant per cycle.
//   - Winner choice:
//       * only one requester active -> it wins
//       * both active, FAIR=1 -> pointer side wins
//       * both active, FAIR=0 -> req0 wins
//   - On grant at edge T: latch A/B/Sel/Id; pointer -> the other requester;
//     go to BUSY.
//   - Requester must hold iReqX and its operands stable until oGntX is seen.
//  BUSY (T+1): addSub_16bit runs from the latched regs. Capture oS/oC/oOvf/oId
//   at the edge; go to RESP.
//  RESP (T+2 onward):
//   - oRValid=1; result stable while iRReady=0; no grants.
//   - iRReady=1 at edge -> IDLE with oRValid=0.
//   - A new grant is possible one cycle after the accepting edge.
//  Latency: grant edge to oRValid = 2 cycles. Peak throughput: 1 op / 3 cycles.
//  Arithmetic: sub = A + ~B + 1, done inside addSub_16bit.
//   - Carry: oC=1 on sub means no borrow (A >= B unsigned).
//   - Overflow: oOvf = Sel ? (A[15]!=B[15] && S[15]!=A[15])
//                          : (A[15]==B[15] && S[15]!=A[15]).
//   - Results wrap modulo 2^16.
//  Boundaries:
//   - Request arriving in BUSY/RESP waits, no grant.
//   - Request dropped before grant is forgotten.
//   - Pointer changes only on a grant.
// STRUCTURE
//  Shared package/header addsub_arb_defs:
//   - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2
//   - requester IDs ID_REQ0=1'b0, ID_REQ1=1'b1
//   - op codes OP_ADD=1'b0, OP_SUB=1'b1
//  One sub-module: existing addSub_16bit (iA, iB, iSel, oS, oC).
//  This block holds the FSM, arbiter, operand regs and result regs.
// TESTING
//  1 Reset: iRst=1 for 2 cycles mid-RESP -> oRValid=0, oS=0, state IDLE,
//    next simultaneous request grants req0.
//  2 Req0 only: 5+3 -> oGnt0 at T; at T+2 oRValid=1, oS=8, oC=0, oOvf=0, oId=0.
//  3 Req1 sub, unsigned: 109-25 -> oS=84, oC=1.
//  4 Req1 sub, signed: 320-347 -> oS=16'hFFE5 (-27), oC=0, oOvf=0, oId=1.
//  5 Both request continuously, FAIR=1 -> grants alternate 0,1,0,1.
//    FAIR=0 -> req0 every time.
//  6 Overflow:
//    - 16'h7FFF+1 -> oS=16'h8000, oOvf=1.
//    - 16'h8000-1 -> oS=16'h7FFF, oOvf=1, oC=1.
//  7 Backpressure: iRReady=0 for 5 cycles -> oS/oId stable, oGnt0/1 stay 0;
//    iRReady=1 -> IDLE next cycle.

Source files
------------

// File: rtl/addsub_arb_defs.sv
// Shared encodings for the two-requester add/sub arbiter: FSM states,
// requester IDs and op codes, plus the signed-overflow rule.
package addsub_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow from sign bits only: add overflows when like signs give an
  // unlike result; sub overflows when unlike signs give a result unlike A.
  function automatic logic signed_ovf(input logic sel, input logic a_msb,
                                      input logic b_msb, input logic s_msb);
    if (sel == OP_SUB) begin
      return (a_msb != b_msb) && (s_msb != a_msb);
    end
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addSub_16bit.sv
// Combinational 16-bit adder/subtractor; subtract is A + ~B + 1 so that
// oC=1 on a subtract means no borrow.
module addSub_16bit
  import addsub_arb_defs::*;
(
  input  logic [15:0] iA,
  input  logic [15:0] iB,
  input  logic        iSel,
  output logic [15:0] oS,
  output logic        oC
);

  logic [15:0] b_eff;

  assign b_eff     = (iSel == OP_ADD) ? iB : ~iB;
  assign {oC, oS}  = {1'b0, iA} + {1'b0, b_eff} + {16'd0, iSel};

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin (or fixed-priority) share of one addSub_16bit between two requesters.
// Grant edge to oRValid is 2 cycles; result held until iRReady, no grants meanwhile.
module addsub_arbiter
  import addsub_arb_defs::*;
#(
  parameter int WIDTH = 16,
  parameter bit FAIR  = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iReq0,
  input  logic [WIDTH-1:0] iA0,
  input  logic [WIDTH-1:0] iB0,
  input  logic             iSel0,
  output logic             oGnt0,
  input  logic             iReq1,
  input  logic [WIDTH-1:0] iA1,
  input  logic [WIDTH-1:0] iB1,
  input  logic             iSel1,
  output logic             oGnt1,
  output logic             oRValid,
  input  logic             iRReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oOvf,
  output logic             oId
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             rid_q, rid_d;
  logic             vld_q, vld_d;

  logic             gnt0, gnt1, win;
  logic [WIDTH-1:0] sum;
  logic             carry;

  addSub_16bit u_addsub (
    .iA   (a_q),
    .iB   (b_q),
    .iSel (sel_q),
    .oS   (sum),
    .oC   (carry)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    id_d    = id_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    rid_d   = rid_q;
    vld_d   = vld_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    win     = ID_REQ0;

    case (state_q)
      ST_IDLE: begin
        if (iReq0 && iReq1) begin
          win = FAIR ? ptr_q : ID_REQ0;
        end else if (iReq1) begin
          win = ID_REQ1;
        end
        if (iReq0 || iReq1) begin
          gnt0    = (win == ID_REQ0);
          gnt1    = (win == ID_REQ1);
          a_d     = (win == ID_REQ1) ? iA1 : iA0;
          b_d     = (win == ID_REQ1) ? iB1 : iB0;
          sel_d   = (win == ID_REQ1) ? iSel1 : iSel0;
          id_d    = win;
          // Pointer only moves on a grant, always to the side that just lost.
          ptr_d   = (win == ID_REQ0) ? ID_REQ1 : ID_REQ0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_d     = sum;
        c_d     = carry;
        ovf_d   = signed_ovf(sel_q, a_q[WIDTH-1], b_q[WIDTH-1], sum[WIDTH-1]);
        rid_d   = id_q;
        vld_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (iRReady) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_REQ0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= OP_ADD;
      id_q    <= ID_REQ0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      rid_q   <= ID_REQ0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      rid_q   <= rid_d;
      vld_q   <= vld_d;
    end
  end

  assign oGnt0   = gnt0;
  assign oGnt1   = gnt1;
  assign oRValid = vld_q;
  assign oS      = s_q;
  assign oC      = c_q;
  assign oOvf    = ovf_q;
  assign oId     = rid_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share inputs.
module tb_addsub_arbiter;

  logic        iClk = 1'b0;
  logic        iRst, iReq0, iReq1, iSel0, iSel1, iRReady;
  logic [15:0] iA0, iB0, iA1, iB1;
  logic        oGnt0, oGnt1, oRValid, oC, oOvf, oId;
  logic [15:0] oS;
  logic        fp_gnt0, fp_gnt1, fp_vld, fp_c, fp_ovf, fp_id;
  logic [15:0] fp_s;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  addsub_arbiter #(.WIDTH(16), .FAIR(1'b1)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReq0(iReq0), .iA0(iA0), .iB0(iB0), .iSel0(iSel0), .oGnt0(oGnt0),
    .iReq1(iReq1), .iA1(iA1), .iB1(iB1), .iSel1(iSel1), .oGnt1(oGnt1),
    .oRValid(oRValid), .iRReady(iRReady),
    .oS(oS), .oC(oC), .oOvf(oOvf), .oId(oId)
  );

  addsub_arbiter #(.WIDTH(16), .FAIR(1'b0)) dut_fp (
    .iClk(iClk), .iRst(iRst),
    .iReq0(iReq0), .iA0(iA0), .iB0(iB0), .iSel0(iSel0), .oGnt0(fp_gnt0),
    .iReq1(iReq1), .iA1(iA1), .iB1(iB1), .iSel1(iSel1), .oGnt1(fp_gnt1),
    .oRValid(fp_vld), .iRReady(iRReady),
    .oS(fp_s), .oC(fp_c), .oOvf(fp_ovf), .oId(fp_id)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic issue(input logic r, input logic [15:0] a, input logic [15:0] b,
                       input logic sel);
    if (r == 1'b0) begin
      iReq0 = 1'b1; iA0 = a; iB0 = b; iSel0 = sel;
    end else begin
      iReq1 = 1'b1; iA1 = a; iB1 = b; iSel1 = sel;
    end
    #1;
  endtask

  // Grant edge, drop requests during BUSY, land in RESP.
  task automatic to_resp();
    tick();
    iReq0 = 1'b0;
    iReq1 = 1'b0;
    tick();
  endtask

  task automatic accept();
    iRReady = 1'b1;
    tick();
    iRReady = 1'b0;
  endtask

  task automatic test_reset();
    issue(1'b0, 16'd5, 16'd3, 1'b0);
    to_resp();
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    total++;
    if (oRValid !== 1'b0 || oS !== 16'd0 || oC !== 1'b0 || oOvf !== 1'b0 || oId !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: vld=%b s=%h c=%b ovf=%b id=%b, want 0 0000 0 0 0",
               oRValid, oS, oC, oOvf, oId);
    end
    issue(1'b0, 16'd1, 16'd1, 1'b0);
    issue(1'b1, 16'd2, 16'd2, 1'b0);
    total++;
    if (oGnt0 !== 1'b1 || oGnt1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_pointer: gnt0=%b gnt1=%b, want 1 0", oGnt0, oGnt1);
    end
    to_resp();
    total++;
    if (oRValid !== 1'b1 || oId !== 1'b0 || oS !== 16'd2) begin
      bad++;
      $display("FAIL reset_first_result: vld=%b id=%b s=%h, want 1 0 0002", oRValid, oId, oS);
    end
    accept();
  endtask

  task automatic test_req0_add();
    issue(1'b0, 16'd5, 16'd3, 1'b0);
    total++;
    if (oGnt0 !== 1'b1 || oGnt1 !== 1'b0) begin
      bad++;
      $display("FAIL req0_grant: gnt0=%b gnt1=%b, want 1 0", oGnt0, oGnt1);
    end
    tick();
    iReq0 = 1'b0;
    total++;
    if (oRValid !== 1'b0 || oGnt0 !== 1'b0) begin
      bad++;
      $display("FAIL req0_busy: vld=%b gnt0=%b, want 0 0", oRValid, oGnt0);
    end
    tick();
    total++;
    if (oRValid !== 1'b1 || oS !== 16'd8 || oC !== 1'b0 || oOvf !== 1'b0 || oId !== 1'b0) begin
      bad++;
      $display("FAIL req0_add: vld=%b s=%h c=%b ovf=%b id=%b, want 1 0008 0 0 0",
               oRValid, oS, oC, oOvf, oId);
    end
    accept();
    total++;
    if (oRValid !== 1'b0) begin
      bad++;
      $display("FAIL req0_accept: vld=%b, want 0", oRValid);
    end
  endtask

  task automatic test_req1_sub();
    issue(1'b1, 16'd109, 16'd25, 1'b1);
    total++;
    if (oGnt1 !== 1'b1 || oGnt0 !== 1'b0) begin
      bad++;
      $display("FAIL req1_grant: gnt0=%b gnt1=%b, want 0 1", oGnt0, oGnt1);
    end
    to_resp();
    total++;
    if (oS !== 16'd84 || oC !== 1'b1 || oOvf !== 1'b0 || oId !== 1'b1) begin
      bad++;
      $display("FAIL sub_unsigned: s=%h c=%b ovf=%b id=%b, want 0054 1 0 1", oS, oC, oOvf, oId);
    end
    accept();
    issue(1'b1, 16'd320, 16'd347, 1'b1);
    to_resp();
    total++;
    if (oS !== 16'hFFE5 || oC !== 1'b0 || oOvf !== 1'b0 || oId !== 1'b1) begin
      bad++;
      $display("FAIL sub_signed: s=%h c=%b ovf=%b id=%b, want ffe5 0 0 1", oS, oC, oOvf, oId);
    end
    accept();
  endtask

  task automatic test_overflow();
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    to_resp();
    total++;
    if (oS !== 16'h8000 || oOvf !== 1'b1 || oC !== 1'b0) begin
      bad++;
      $display("FAIL ovf_add: s=%h ovf=%b c=%b, want 8000 1 0", oS, oOvf, oC);
    end
    accept();
    issue(1'b1, 16'h8000, 16'h0001, 1'b1);
    to_resp();
    total++;
    if (oS !== 16'h7FFF || oOvf !== 1'b1 || oC !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sub: s=%h ovf=%b c=%b, want 7fff 1 1", oS, oOvf, oC);
    end
    accept();
  endtask

  task automatic test_fairness();
    logic [15:0] exp_s;
    logic        exp_id;
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    issue(1'b0, 16'd10, 16'd1, 1'b0);
    issue(1'b1, 16'd20, 16'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      exp_s  = exp_id ? 16'd18 : 16'd11;
      total++;
      if (oGnt0 !== !exp_id || oGnt1 !== exp_id) begin
        bad++;
        $display("FAIL rr_grant[%0d]: gnt0=%b gnt1=%b, want %b %b", i, oGnt0, oGnt1, !exp_id, exp_id);
      end
      total++;
      if (fp_gnt0 !== 1'b1 || fp_gnt1 !== 1'b0) begin
        bad++;
        $display("FAIL fixed_grant[%0d]: gnt0=%b gnt1=%b, want 1 0", i, fp_gnt0, fp_gnt1);
      end
      tick();
      tick();
      total++;
      if (oId !== exp_id || oS !== exp_s || fp_id !== 1'b0 || fp_s !== 16'd11) begin
        bad++;
        $display("FAIL alt_result[%0d]: id=%b s=%h fp_id=%b fp_s=%h, want %b %h 0 000b",
                 i, oId, oS, fp_id, fp_s, exp_id, exp_s);
      end
      accept();
    end
    iReq0 = 1'b0;
    iReq1 = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(1'b0, 16'h1234, 16'h0001, 1'b0);
    to_resp();
    issue(1'b0, 16'h0002, 16'h0002, 1'b0);
    issue(1'b1, 16'h0003, 16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (oRValid !== 1'b1 || oS !== 16'h1235 || oId !== 1'b0 || oGnt0 !== 1'b0 || oGnt1 !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: vld=%b s=%h id=%b gnt=%b%b, want 1 1235 0 00",
                 i, oRValid, oS, oId, oGnt0, oGnt1);
      end
      tick();
    end
    accept();
    total++;
    if (oRValid !== 1'b0 || oGnt1 !== 1'b1 || oGnt0 !== 1'b0) begin
      bad++;
      $display("FAIL release: vld=%b gnt0=%b gnt1=%b, want 0 0 1", oRValid, oGnt0, oGnt1);
    end
    iReq0 = 1'b0;
    iReq1 = 1'b0;
    tick();
    tick();
    total++;
    if (oRValid !== 1'b0 || oGnt0 !== 1'b0 || oGnt1 !== 1'b0) begin
      bad++;
      $display("FAIL dropped_req: vld=%b gnt=%b%b, want 0 00", oRValid, oGnt0, oGnt1);
    end
  endtask

  initial begin
    iRst = 1'b1; iReq0 = 1'b0; iReq1 = 1'b0; iRReady = 1'b0;
    iA0 = '0; iB0 = '0; iSel0 = 1'b0; iA1 = '0; iB1 = '0; iSel1 = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
    total++;
    if (oRValid !== 1'b0 || oS !== 16'd0 || oGnt0 !== 1'b0 || oGnt1 !== 1'b0) begin
      bad++;
      $display("FAIL power_on: vld=%b s=%h gnt=%b%b, want 0 0000 00", oRValid, oS, oGnt0, oGnt1);
    end
    test_reset();
    test_req0_add();
    test_req1_sub();
    test_overflow();
    test_fairness();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
